// File: rtl/hazard_md_ctrl_pkg.sv
// Shared types and constants for the MIPS hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_hazard_pkg;

  // Register index as carried by the pipeline stage registers
  typedef logic [4:0] reg_idx_t;

  // ALU operand source select for the E stage
  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;  // register file value
  localparam fwd_sel_t FWD_WB  = 2'b01;  // result being written back in W
  localparam fwd_sel_t FWD_MEM = 2'b10;  // ALU result sitting in M

  localparam reg_idx_t REG_ZERO = 5'd0;

  // Multiply/divide sequencer state
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // A source register is produced by a later stage when that stage writes
  // the same register. $zero is hard-wired, so it never counts as a hit.
  function automatic logic reg_hit(input reg_idx_t src,
                                   input reg_idx_t dst,
                                   input logic     we);
    return we && (src != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_md_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: stage fields in, controls out.
// Latency: n/a (wires only).
// Backpressure: n/a; stalls are expressed through StallF/StallD/FlushE.
interface hazard_md_ctrl_if;
  import mips_hazard_pkg::*;

  // Decode-stage sources and control
  reg_idx_t RsD;
  reg_idx_t RtD;
  logic     BranchD;
  logic     MdUseD;

  // Execute-stage sources, destination and control
  reg_idx_t RsE;
  reg_idx_t RtE;
  reg_idx_t WriteRegE;
  logic     RegWriteE;
  logic     MemToRegE;
  logic     MdStartE;
  logic     MdOpE;

  // Memory / writeback destinations
  reg_idx_t WriteRegM;
  logic     RegWriteM;
  logic     MemToRegM;
  reg_idx_t WriteRegW;
  logic     RegWriteW;

  // Controls back to the pipeline
  logic     ForwardAD;
  logic     ForwardBD;
  fwd_sel_t ForwardAE;
  fwd_sel_t ForwardBE;
  logic     StallF;
  logic     StallD;
  logic     FlushE;
  logic     MdBusy;
  logic     MdDone;

  // Pipeline side: drives stage fields, consumes controls
  modport master (
    output RsD, RtD, BranchD, MdUseD,
    output RsE, RtE, WriteRegE, RegWriteE, MemToRegE, MdStartE, MdOpE,
    output WriteRegM, RegWriteM, MemToRegM, WriteRegW, RegWriteW,
    input  ForwardAD, ForwardBD, ForwardAE, ForwardBE,
    input  StallF, StallD, FlushE, MdBusy, MdDone
  );

  // Hazard controller side
  modport slave (
    input  RsD, RtD, BranchD, MdUseD,
    input  RsE, RtE, WriteRegE, RegWriteE, MemToRegE, MdStartE, MdOpE,
    input  WriteRegM, RegWriteM, MemToRegM, WriteRegW, RegWriteW,
    output ForwardAD, ForwardBD, ForwardAE, ForwardBE,
    output StallF, StallD, FlushE, MdBusy, MdDone
  );

endinterface

// File: rtl/hazard_md_ctrl_md_busy_timer.sv
// Multiply/divide busy sequencer: IDLE/BUSY FSM with a down-counter.
// Latency: busy rises the edge after start and stays high N cycles; done marks the Nth.
// Backpressure: none; a start while busy is ignored (decode stall keeps it from happening).
module md_busy_timer
  import mips_hazard_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_op_div,
  output logic o_busy,
  output logic o_done
);

  // Counter holds the number of busy cycles still to come after the current one
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] w_load;

  // Select the latency of the operation being launched
  assign w_load = i_op_div ? DIV_LOAD : MUL_LOAD;

  // Sequencer: busy/done are registered alongside state so they leave glitch-free
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_start) begin
            r_state <= MD_BUSY;
            r_cnt   <= w_load;
            r_busy  <= 1'b1;
            // A one-cycle operation is done in its first busy cycle
            r_done  <= (w_load == '0);
          end
        end
        MD_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_done <= (r_cnt == CNT_W'(1));
          end else begin
            r_state <= MD_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= MD_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/hazard_md_ctrl.sv
// Hazard controller: forwarding selects, F/D stall, E flush, mul/div sequencing.
// Latency: forwarding and stall are combinational (zero cycles); MdBusy/MdDone registered.
// Backpressure: stalls F/D and bubbles E on load-use, branch-compare and HI/LO hazards.
// Optional: HAZARD_STATS_EN adds a saturating StallCnt of cycles with StallD high.
module hazard_md_ctrl
  import mips_hazard_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic              CLK,
  input  logic              rst_n,
  hazard_md_ctrl_if.slave   hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       StallCnt
`endif
);

  fwd_sel_t w_fwd_ae;
  fwd_sel_t w_fwd_be;
  logic     w_fwd_ad;
  logic     w_fwd_bd;
  logic     w_lwstall;
  logic     w_brstall;
  logic     w_mdstall;
  logic     w_stall;
  logic     w_md_busy;
  logic     w_md_done;

  // E-stage operand A: M result is newer than W, so it wins
  always_comb begin
    w_fwd_ae = FWD_RF;
    if (reg_hit(hz.RsE, hz.WriteRegM, hz.RegWriteM)) begin
      w_fwd_ae = FWD_MEM;
    end else if (reg_hit(hz.RsE, hz.WriteRegW, hz.RegWriteW)) begin
      w_fwd_ae = FWD_WB;
    end
  end

  // E-stage operand B: same priority as operand A
  always_comb begin
    w_fwd_be = FWD_RF;
    if (reg_hit(hz.RtE, hz.WriteRegM, hz.RegWriteM)) begin
      w_fwd_be = FWD_MEM;
    end else if (reg_hit(hz.RtE, hz.WriteRegW, hz.RegWriteW)) begin
      w_fwd_be = FWD_WB;
    end
  end

  // Branch compare in D can only take the ALU result from M
  assign w_fwd_ad = reg_hit(hz.RsD, hz.WriteRegM, hz.RegWriteM);
  assign w_fwd_bd = reg_hit(hz.RtD, hz.WriteRegM, hz.RegWriteM);

  // Load in E: its data is not available until after M, so D must wait a cycle
  assign w_lwstall = reg_hit(hz.RsD, hz.RtE, hz.MemToRegE) ||
                     reg_hit(hz.RtD, hz.RtE, hz.MemToRegE);

  // Branch in D needs a result still being computed in E or loaded in M
  assign w_brstall = hz.BranchD &&
                     (reg_hit(hz.RsD, hz.WriteRegE, hz.RegWriteE) ||
                      reg_hit(hz.RtD, hz.WriteRegE, hz.RegWriteE) ||
                      reg_hit(hz.RsD, hz.WriteRegM, hz.MemToRegM) ||
                      reg_hit(hz.RtD, hz.WriteRegM, hz.MemToRegM));

  // HI/LO consumer waits while the unit runs, including the cycle it is launched
  assign w_mdstall = hz.MdUseD && (w_md_busy || hz.MdStartE);

  assign w_stall = w_lwstall || w_brstall || w_mdstall;

  md_busy_timer #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_busy_timer (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .i_start  (hz.MdStartE),
    .i_op_div (hz.MdOpE),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done)
  );

  assign hz.ForwardAE = w_fwd_ae;
  assign hz.ForwardBE = w_fwd_be;
  assign hz.ForwardAD = w_fwd_ad;
  assign hz.ForwardBD = w_fwd_bd;
  assign hz.StallF    = w_stall;
  assign hz.StallD    = w_stall;
  assign hz.FlushE    = w_stall;
  assign hz.MdBusy    = w_md_busy;
  assign hz.MdDone    = w_md_done;

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;

  // Count decode-stall cycles, holding at all-ones instead of wrapping
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign StallCnt = r_stall_cnt;
`endif

endmodule
